// File: rtl/e_mdu_ext.sv
// e_mdu_ext: multicycle multiply/divide unit with HI/LO, madd/msub, mthi/mtlo and cancel.
// Operands and the {HI,LO} snapshot are latched at Start; results commit on the edge Busy falls.
module e_mdu_ext #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic             Start,
    input  logic             Cancel,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3, OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MADD  = 4'd7, OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9, OP_MSUBU = 4'd10;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0]   snap_q, snap_d;

    logic                 start_mul, start_div, is_mul, sgn, a_neg, b_neg;
    logic [2*WIDTH-1:0]   ax, bx, prod, acc;
    logic [WIDTH-1:0]     a_abs, b_abs, b_safe, uq, ur, q, r;

    assign start_mul = MDUOp inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign start_div = MDUOp inside {OP_DIV, OP_DIVU};
    assign is_mul    = op_q inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign sgn       = op_q inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};

    // Extending to 2*WIDTH before multiplying makes the low 2*WIDTH bits the exact product.
    assign ax   = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign bx   = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod = ax * bx;
    assign acc  = (op_q inside {OP_MADD, OP_MADDU}) ? snap_q + prod :
                  (op_q inside {OP_MSUB, OP_MSUBU}) ? snap_q - prod : prod;

    // Sign-magnitude divide; most-negative / -1 wraps back to D1 with zero remainder.
    assign a_neg  = sgn & a_q[WIDTH-1];
    assign b_neg  = sgn & b_q[WIDTH-1];
    assign a_abs  = a_neg ? -a_q : a_q;
    assign b_abs  = b_neg ? -b_q : b_q;
    assign b_safe = (b_abs == '0) ? WIDTH'(1) : b_abs;
    assign uq     = a_abs / b_safe;
    assign ur     = a_abs % b_safe;
    assign q      = (a_neg ^ b_neg) ? -uq : uq;
    assign r      = a_neg ? -ur : ur;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        snap_d  = snap_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (Start && !Cancel && (start_mul || start_div)) begin
                state_d = RUN;
                cnt_d   = start_mul ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
                op_d    = MDUOp;
                a_d     = D1;
                b_d     = D2;
                snap_d  = {hi_q, lo_q};
            end else if (!Cancel) begin
                hi_d = (MDUOp == OP_MTHI) ? D1 : hi_q;
                lo_d = (MDUOp == OP_MTLO) ? D1 : lo_q;
            end
        end else if (Cancel || cnt_q == 8'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (!Cancel && is_mul) begin
                {hi_d, lo_d} = acc;
            end else if (!Cancel && b_q != '0) begin
                hi_d = r;
                lo_d = q;
            end
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            snap_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            snap_q  <= snap_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule
